mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM that sequences fetch/decode/execute and drives
//  the datapath muxes, write strobes and the 3-bit ALU op code. Consumes the ALU zero/overflow
//  flags. Sits between the instruction register and the datapath (PC, memory, regfile, ALU).
// PARAMETERS
//  STATE_W  4  width of state register / state_o debug port (fixed >=4)
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  reset       in   1  asynchronous, active-high
//  opcode      in   6  IR[31:26], valid from DECODE onward
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU z (result==0)
//  ov          in   1  ALU signed overflow (meaningful only for ADD/SUB ops)
//  pc_en       out  1  PC load = pc_write | (branch & zero)
//  iord        out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  mem_write   out  1  memory write strobe
//  ir_write    out  1  instruction register load
//  reg_dst     out  1  0: rt, 1: rd
//  mem_to_reg  out  1  0: ALUOut, 1: MDR to regfile
//  reg_write   out  1  regfile write strobe
//  alu_src_a   out  1  0: PC, 1: A
//  alu_src_b   out  2  00: B, 01: const 4, 10: signext imm, 11: signext imm<<2
//  pc_src      out  2  00: ALU result, 01: ALUOut, 10: jump target, 11: exception vector
//  alu_op      out  3  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed-less-than flag)
//  exc         out  1  overflow exception pulse (tied 0 without macro)
//  state_o     out  4  current state, debug
// BEHAVIOUR
//  - Moore outputs decoded from registered state; next state from state+opcode+funct+ov.
//  - Reset: state=FETCH(0) immediately; while reset=1 pc_en, ir_write, mem_write, reg_write,
//    exc forced 0; other outputs take FETCH values. First fetch on first edge after release.
//  - Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
//  - Unlisted outputs in a state are 0; alu_op defaults to ADD(2).
//  0 FETCH   : iord=0 ir_write=1 srcA=0 srcB=01 ADD pc_src=00 pc_write -> DECODE
//  1 DECODE  : srcA=0 srcB=11 ADD (branch target into ALUOut) -> by opcode:
//              LW/SW->MEMADR, R->RTYPEEX, BEQ->BEQEX, ADDI->ADDIEX, J->JEX, other->FETCH (NOP)
//  2 MEMADR  : srcA=1 srcB=10 ADD -> LW:MEMRD, SW:MEMWR
//  3 MEMRD   : iord=1 -> MEMWB
//  4 MEMWB   : reg_dst=0 mem_to_reg=1 reg_write=1 -> FETCH
//  5 MEMWR   : iord=1 mem_write=1 -> FETCH
//  6 RTYPEEX : srcA=1 srcB=00; funct 0x20 ADD,0x22 SUB,0x24 AND,0x25 OR,0x2A SLT -> RTYPEWB;
//              unsupported funct -> FETCH, no writeback
//  7 RTYPEWB : reg_dst=1 mem_to_reg=0 reg_write=1 -> FETCH
//  8 BEQEX   : srcA=1 srcB=00 SUB pc_src=01 branch=1 -> FETCH (pc_en = zero)
//  9 ADDIEX  : srcA=1 srcB=10 ADD -> ADDIWB
// 10 ADDIWB  : reg_dst=0 mem_to_reg=0 reg_write=1 -> FETCH
// 11 JEX     : pc_src=10 pc_write=1 -> FETCH
// 12 EXC     : pc_src=11 pc_write=1 exc=1 -> FETCH (macro only)
//  - Unused encodings 13-15 (and 12 without macro) -> FETCH next cycle, all strobes 0.
//  - CPI: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, NOP 2.
//  - Reset mid-instruction: abort, no further strobes; restart at FETCH.
// CONFIGURATION
//  OVERFLOW_TRAP_EN defined: in RTYPEEX with funct ADD/SUB, or ADDIEX, ov=1 at clock edge ->
//   EXC instead of writeback (regfile untouched); exc=1 for exactly one cycle, PC<=vector.
//   ov ignored for AND/OR/SLT (flag is stale there).
//  Undefined: ov ignored entirely, EXC unreachable, exc tied 0, overflowed result written.
// TESTING
//  - reset pulse mid-MEMRD -> state_o=0 async, strobes 0; after release LW takes 5 cycles.
//  - LW (100011): states 0,1,2,3,4; MEMRD iord=1; MEMWB reg_write=1 mem_to_reg=1 reg_dst=0.
//  - R funct 0x2A -> RTYPEEX alu_op=7; funct 0x22 -> alu_op=6; funct 0x3F -> no reg_write.
//  - BEQ zero=1 -> pc_en=1 pc_src=01 in BEQEX; zero=0 -> pc_en=0; back to FETCH either way.
//  - J -> JEX pc_src=10 pc_en=1; opcode 111111 -> DECODE then FETCH, no strobes.
//  - ADDI ov=1: with OVERFLOW_TRAP_EN -> EXC, exc=1 one cycle, no reg_write; without -> ADDIWB.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main controller (Moore FSM driving datapath muxes/strobes)
// Define OVERFLOW_TRAP_EN to divert overflowing ADD/SUB/ADDI to the EXC state.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               ov,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_op,
  output logic               exc,
  output logic [STATE_W-1:0] state_o
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_EXC
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t r_state, w_next;
  logic w_pc_write, w_branch, w_ir_write, w_mem_write, w_reg_write, w_exc;
  logic w_funct_ok, w_addsub, w_trap;
  logic [2:0] w_r_op;
  assign w_addsub = funct == 6'h20 || funct == 6'h22;
`ifdef OVERFLOW_TRAP_EN
  assign w_trap = ov;
`else
  logic w_unused_ov;
  assign w_unused_ov = ov;
  assign w_trap = 1'b0;
`endif
  always_comb begin
    w_funct_ok = 1'b1;
    w_r_op = 3'd2;
    case (funct)
      6'h20: w_r_op = 3'd2;
      6'h22: w_r_op = 3'd6;
      6'h24: w_r_op = 3'd0;
      6'h25: w_r_op = 3'd1;
      6'h2A: w_r_op = 3'd7;
      default: w_funct_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = S_FETCH;
    iord = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    w_reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    alu_op = 3'd2;
    w_pc_write = 1'b0;
    w_branch = 1'b0;
    w_exc = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        alu_src_b = 2'b01;
        w_pc_write = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                 opcode == OP_R    ? S_RTYPEEX :
                 opcode == OP_BEQ  ? S_BEQEX   :
                 opcode == OP_ADDI ? S_ADDIEX  :
                 opcode == OP_J    ? S_JEX     : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next = opcode == OP_LW ? S_MEMRD : opcode == OP_SW ? S_MEMWR : S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        w_mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op = w_r_op;
        w_next = !w_funct_ok ? S_FETCH : (w_addsub && w_trap) ? S_EXC : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op = 3'd6;
        pc_src = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next = w_trap ? S_EXC : S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JEX: begin
        pc_src = 2'b10;
        w_pc_write = 1'b1;
      end
`ifdef OVERFLOW_TRAP_EN
      S_EXC: begin
        pc_src = 2'b11;
        w_pc_write = 1'b1;
        w_exc = 1'b1;
      end
`endif
      default: ;
    endcase
  end
  // strobes are suppressed combinationally so an asserted reset aborts immediately
  assign pc_en = ~reset & (w_pc_write | (w_branch & zero));
  assign ir_write = ~reset & w_ir_write;
  assign mem_write = ~reset & w_mem_write;
  assign reg_write = ~reset & w_reg_write;
  assign exc = ~reset & w_exc;
  assign state_o = STATE_W'(r_state);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction stream checked against a per-instruction state-path model
module tb_mips_multicycle_ctrl;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [16:0] RST_OUT = 17'b0_0_0_0_0_0_0_0_01_00_010_0;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, ov = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, exc;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  int n_vec = 0, n_err = 0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .ov(ov),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .exc(exc), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_out();
    return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, pc_src, alu_op, exc};
  endfunction

  // expected Moore outputs of each named state, straight from the state table
  function automatic logic [16:0] exp_out(input int s, input logic z, input logic [5:0] fn);
    logic pcw = 0, br = 0, io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ex = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] op = 3'd2;
    case (s)
      0: begin irw = 1; sb = 2'b01; pcw = 1; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: io = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin io = 1; mw = 1; end
      6: begin
        sa = 1;
        op = fn == 6'h22 ? 3'd6 : fn == 6'h24 ? 3'd0 : fn == 6'h25 ? 3'd1 :
             fn == 6'h2A ? 3'd7 : 3'd2;
      end
      7: begin rd = 1; rw = 1; end
      8: begin sa = 1; op = 3'd6; ps = 2'b01; br = 1; end
      9: begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      12: begin ps = 2'b11; pcw = 1; ex = 1; end
      default: ;
    endcase
    return {pcw | (br & z), io, mw, irw, rd, m2r, rw, sa, sb, ps, op, ex};
  endfunction

  // zf<0: random zero each cycle; abort_at>=0: assert reset while in that path step
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovv,
                           input int zf, input int abort_at);
    int path[$];
    bit fn_ok, trap_hit;
    fn_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    trap_hit = TRAP && ovv;
    path = {0, 1};
    case (op)
      LW: path = {path, 2, 3, 4};
      SW: path = {path, 2, 5};
      RT: path = fn_ok ? {path, 6, (trap_hit && (fn == 6'h20 || fn == 6'h22)) ? 12 : 7} : {path, 6};
      BEQ: path = {path, 8};
      ADDI: path = {path, 9, trap_hit ? 12 : 10};
      JMP: path = {path, 11};
      default: ;
    endcase
    opcode = op;
    funct = fn;
    ov = ovv;
    foreach (path[i]) begin
      zero = zf < 0 ? 1'($urandom_range(0, 1)) : zf[0];
      #1;
      chk("state", 32'(state_o), 32'(path[i]));
      chk("outputs", 32'(dut_out()), 32'(exp_out(path[i], zero, fn)));
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_outputs", 32'(dut_out()), 32'(RST_OUT));
        @(posedge clk);
        #1;
        chk("abort_hold", 32'(dut_out()), 32'(RST_OUT));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    #1 reset = 1'b1;
    #2;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outputs", 32'(dut_out()), 32'(RST_OUT));
    zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 32'(dut_out()), 32'(RST_OUT));
    @(negedge clk);
    reset = 1'b0;
    run_instr(LW, 6'h00, 1'b0, -1, -1);
    run_instr(LW, 6'h00, 1'b0, -1, 3);
    run_instr(LW, 6'h00, 1'b0, -1, -1);
    run_instr(SW, 6'h00, 1'b0, -1, -1);
    run_instr(RT, 6'h2A, 1'b1, -1, -1);
    run_instr(RT, 6'h22, 1'b0, -1, -1);
    run_instr(RT, 6'h20, 1'b1, -1, -1);
    run_instr(RT, 6'h3F, 1'b0, -1, -1);
    run_instr(BEQ, 6'h00, 1'b0, 1, -1);
    run_instr(BEQ, 6'h00, 1'b0, 0, -1);
    run_instr(JMP, 6'h00, 1'b0, 1, -1);
    run_instr(6'b111111, 6'h00, 1'b0, 1, -1);
    run_instr(ADDI, 6'h00, 1'b1, -1, -1);
    run_instr(ADDI, 6'h00, 1'b0, -1, -1);
    ops = '{RT, LW, SW, BEQ, ADDI, JMP, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    for (int k = 0; k < 300; k++) begin
      int oi, fi;
      logic [5:0] op, fn;
      oi = int'($urandom_range(0, 6));
      fi = int'($urandom_range(0, 5));
      op = oi == 6 ? 6'($urandom) : ops[oi];
      fn = fi == 5 ? 6'($urandom) : fns[fi];
      run_instr(op, fn, 1'($urandom_range(0, 1)), -1, ($urandom_range(0, 19) == 0) ? 2 : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
